// File: rtl/mini_src_pkg.sv
// Shared opcode, ALU code, state and instruction-class definitions for the Mini SRC control path.
package mini_src_pkg;

   localparam logic [4:0] OP_LD       = 5'b00000;
   localparam logic [4:0] OP_LDI      = 5'b00001;
   localparam logic [4:0] OP_ST       = 5'b00010;
   localparam logic [4:0] OP_REG_LO   = 5'b00011;
   localparam logic [4:0] OP_REG_HI   = 5'b01011;
   localparam logic [4:0] OP_ADDI     = 5'b01100;
   localparam logic [4:0] OP_ANDI     = 5'b01101;
   localparam logic [4:0] OP_ORI      = 5'b01110;
   localparam logic [4:0] OP_NOP      = 5'b11010;
   localparam logic [4:0] OP_HALT     = 5'b11011;

   localparam logic [4:0] ALU_ADD     = 5'b00011;
   localparam logic [4:0] ALU_AND     = 5'b00101;
   localparam logic [4:0] ALU_OR      = 5'b00110;

   typedef enum logic [3:0] {
      S_RESET,
      S_T0,
      S_T1,
      S_T2,
      S_T3,
      S_T4,
      S_T5,
      S_T6,
      S_T7,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_REG,
      C_IMM,
      C_LDI,
      C_LD,
      C_ST,
      C_NOP,
      C_HALT
   } class_t;

endpackage

// File: rtl/opcode_classifier.sv
// Maps the 5-bit opcode to its instruction class and the ALU code used in T4.
module opcode_classifier
   import mini_src_pkg::*;
(
   input  logic [4:0] opcode,
   output class_t     op_class,
   output logic [4:0] alu_op
);

   // Register-register ops pass their opcode straight through as the ALU code.
   always_comb begin
      op_class = C_NOP;
      alu_op   = ALU_ADD;
      if (opcode >= OP_REG_LO && opcode <= OP_REG_HI) begin
         op_class = C_REG;
         alu_op   = opcode;
      end else begin
         case (opcode)
            OP_ADDI: begin op_class = C_IMM;  alu_op = ALU_ADD; end
            OP_ANDI: begin op_class = C_IMM;  alu_op = ALU_AND; end
            OP_ORI:  begin op_class = C_IMM;  alu_op = ALU_OR;  end
            OP_LDI:  op_class = C_LDI;
            OP_LD:   op_class = C_LD;
            OP_ST:   op_class = C_ST;
            OP_HALT: op_class = C_HALT;
            default: op_class = C_NOP;
         endcase
      end
   end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the Mini SRC datapath: fetch, decode, per-class execute, memory wait handshake.
module control_unit
   import mini_src_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] IR,
   input  logic        mem_ready,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        Zlowout,
   output logic        Cout,
   output logic        Read,
   output logic        Write,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic [4:0]  alu_op,
   output logic        run
);

   state_t     state;
   state_t     next_state;
   class_t     op_class;
   logic [4:0] class_alu_op;

   // Operand fields are consumed by the datapath, not by the sequencer.
   logic unused_ir_fields;
   assign unused_ir_fields = ^IR[26:0];

   opcode_classifier u_classifier (
      .opcode   (IR[31:27]),
      .op_class (op_class),
      .alu_op   (class_alu_op)
   );

   always_ff @(posedge clock) begin
      if (!reset_n)
         state <= S_RESET;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      PCout   = 1'b0;
      PCin    = 1'b0;
      IncPC   = 1'b0;
      MARin   = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      IRin    = 1'b0;
      Yin     = 1'b0;
      Zin     = 1'b0;
      Zlowout = 1'b0;
      Cout    = 1'b0;
      Read    = 1'b0;
      Write   = 1'b0;
      Gra     = 1'b0;
      Grb     = 1'b0;
      Grc     = 1'b0;
      Rin     = 1'b0;
      Rout    = 1'b0;
      BAout   = 1'b0;
      alu_op  = ALU_ADD;
      run     = 1'b1;

      case (state)
         S_RESET: begin
            run        = 1'b0;
            next_state = S_T0;
         end
         S_T0: begin
            PCout      = 1'b1;
            MARin      = 1'b1;
            IncPC      = 1'b1;
            Zin        = 1'b1;
            next_state = S_T1;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
            if (mem_ready)
               next_state = S_T2;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
            case (op_class)
               C_NOP:   next_state = S_T0;
               C_HALT:  next_state = S_HALT;
               default: next_state = S_T3;
            endcase
         end
         // Register ops read Rb; the load/store/ldi family uses base-address gating so R0 reads as zero.
         S_T3: begin
            Grb = 1'b1;
            Yin = 1'b1;
            if (op_class == C_REG || op_class == C_IMM)
               Rout = 1'b1;
            else
               BAout = 1'b1;
            next_state = S_T4;
         end
         S_T4: begin
            Zin = 1'b1;
            if (op_class == C_REG) begin
               Grc    = 1'b1;
               Rout   = 1'b1;
               alu_op = class_alu_op;
            end else if (op_class == C_IMM) begin
               Cout   = 1'b1;
               alu_op = class_alu_op;
            end else begin
               Cout = 1'b1;
            end
            next_state = S_T5;
         end
         S_T5: begin
            Zlowout = 1'b1;
            if (op_class == C_LD || op_class == C_ST) begin
               MARin      = 1'b1;
               next_state = S_T6;
            end else begin
               Gra        = 1'b1;
               Rin        = 1'b1;
               next_state = S_T0;
            end
         end
         S_T6: begin
            MDRin = 1'b1;
            if (op_class == C_LD) begin
               Read = 1'b1;
               if (mem_ready)
                  next_state = S_T7;
            end else begin
               Gra        = 1'b1;
               Rout       = 1'b1;
               next_state = S_T7;
            end
         end
         S_T7: begin
            if (op_class == C_LD) begin
               MDRout     = 1'b1;
               Gra        = 1'b1;
               Rin        = 1'b1;
               next_state = S_T0;
            end else begin
               Write = 1'b1;
               if (mem_ready)
                  next_state = S_T0;
            end
         end
         S_HALT: begin
            run        = 1'b0;
            next_state = S_HALT;
         end
         default: begin
            run        = 1'b0;
            next_state = S_RESET;
         end
      endcase
   end

endmodule
